// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per request: load operands, let them settle,
// strobe the flag register, read the result bus, then hold a response until taken.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       SU,
  output logic       FI,
  output logic       E0,
  input  logic [7:0] BUS,
  input  logic       CF,
  input  logic       ZF,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_cf,
  output logic       rsp_zf,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    FLAG   = 3'd2,
    READ   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  // Counter counts down to zero, so SETTLE spans SETTLE_CYC cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       su_q, su_d;
  logic [1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_cf_q, rsp_cf_d;
  logic       rsp_zf_q, rsp_zf_d;
  logic [7:0] op_count_q, op_count_d;
  logic       flag_strobe;
  logic       result_oe;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      su_q        <= 1'b0;
      op_q        <= OP_ADD;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_cf_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
      op_count_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      su_q        <= su_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_cf_q    <= rsp_cf_d;
      rsp_zf_q    <= rsp_zf_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    su_d        = su_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_cf_d    = rsp_cf_q;
    rsp_zf_d    = rsp_zf_q;
    op_count_d  = op_count_q;
    flag_strobe = 1'b0;
    result_oe   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = (req_op == OP_INC) ? 8'h01 : req_b;
          su_d    = (req_op == OP_SUB) || (req_op == OP_CMP);
          op_d    = req_op;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = FLAG;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FLAG: begin
        flag_strobe = 1'b1;
        state_d     = READ;
      end
      READ: begin
        // CMP only updates flags; the bus is never enabled and the data reads as zero.
        result_oe   = (op_q != OP_CMP);
        rsp_data_d  = (op_q == OP_CMP) ? 8'h00 : BUS;
        rsp_cf_d    = CF;
        rsp_zf_d    = ZF;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign A         = a_q;
  assign B         = b_q;
  assign SU        = su_q;
  assign FI        = flag_strobe;
  assign E0        = result_oe;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cf    = rsp_cf_q;
  assign rsp_zf    = rsp_zf_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU attached to A/B/SU/FI/E0.
module tb_alu_op_sequencer;

  localparam int S = 1;

  logic       CLK;
  logic       CLR;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [7:0] A;
  logic [7:0] B;
  logic       SU;
  logic       FI;
  logic       E0;
  logic [7:0] BUS;
  logic       CF;
  logic       ZF;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_cf;
  logic       rsp_zf;
  logic [7:0] op_count;

  int n_cmp;
  int n_bad;

  alu_op_sequencer #(.SETTLE_CYC(S)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .A         (A),
    .B         (B),
    .SU        (SU),
    .FI        (FI),
    .E0        (E0),
    .BUS       (BUS),
    .CF        (CF),
    .ZF        (ZF),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cf    (rsp_cf),
    .rsp_zf    (rsp_zf),
    .op_count  (op_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: carry on subtract means no borrow; bus shows junk when not enabled.
  logic [7:0] alu_res;
  logic       alu_c;
  always_comb begin
    if (SU) {alu_c, alu_res} = {1'b0, A} + {1'b0, ~B} + 9'd1;
    else    {alu_c, alu_res} = {1'b0, A} + {1'b0, B};
  end
  assign BUS = E0 ? alu_res : 8'hA5;
  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      CF <= 1'b0;
      ZF <= 1'b0;
    end else if (FI) begin
      CF <= alu_c;
      ZF <= (alu_res == 8'h00);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready: got %b want 1", req_ready);
    end
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge CLK);
  endtask

  // Called right after the accept edge; follows the op until rsp_valid is seen.
  task automatic run_to_resp(input string nm, input logic hold,
                             input logic [7:0] ea, input logic [7:0] eb, input logic esu,
                             input logic ee0, input logic [7:0] ed, input logic ecf,
                             input logic ezf);
    int fi_first, fi_n, e0_first, e0_n, rv_first, overlap, opnd_chg;
    fi_first = -1; fi_n = 0; e0_first = -1; e0_n = 0; rv_first = -1;
    overlap = 0; opnd_chg = 0;
    @(negedge CLK);
    n_cmp++;
    if (A !== ea || B !== eb || SU !== esu) begin
      n_bad++;
      $display("FAIL %s_operands: got A=%h B=%h SU=%b want A=%h B=%h SU=%b", nm, A, B, SU, ea, eb, esu);
    end
    n_cmp++;
    if (req_ready !== 1'b0 || FI !== 1'b0 || E0 !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_settle_outs: got rdy=%b FI=%b E0=%b rv=%b want 0 0 0 0", nm, req_ready, FI, E0, rsp_valid);
    end
    if (!hold) req_valid = 1'b0;
    for (int n = 1; n < 16; n++) begin
      @(negedge CLK);
      if (FI) begin fi_n++; if (fi_first < 0) fi_first = n; end
      if (E0) begin e0_n++; if (e0_first < 0) e0_first = n; end
      if (FI && E0) overlap++;
      if (A !== ea || B !== eb || SU !== esu) opnd_chg++;
      if (rsp_valid) begin rv_first = n; break; end
    end
    n_cmp++;
    if (rv_first != S + 2) begin
      n_bad++;
      $display("FAIL %s_rsp_latency: got %0d want %0d", nm, rv_first, S + 2);
    end
    n_cmp++;
    if (fi_first != S || fi_n != 1) begin
      n_bad++;
      $display("FAIL %s_fi_pulse: got first=%0d count=%0d want first=%0d count=1", nm, fi_first, fi_n, S);
    end
    n_cmp++;
    if (ee0 ? (e0_first != S + 1 || e0_n != 1) : (e0_n != 0)) begin
      n_bad++;
      $display("FAIL %s_e0_pulse: got first=%0d count=%0d want enabled=%b", nm, e0_first, e0_n, ee0);
    end
    n_cmp++;
    if (overlap != 0 || opnd_chg != 0) begin
      n_bad++;
      $display("FAIL %s_stability: got overlap=%0d operand_changes=%0d want 0 0", nm, overlap, opnd_chg);
    end
    n_cmp++;
    if (rsp_data !== ed || rsp_cf !== ecf || rsp_zf !== ezf) begin
      n_bad++;
      $display("FAIL %s_result: got data=%h cf=%b zf=%b want data=%h cf=%b zf=%b", nm, rsp_data, rsp_cf, rsp_zf, ed, ecf, ezf);
    end
  endtask

  // rsp_ready is already high: the handshake happens on the edge after rsp_valid rises.
  task automatic check_done(input string nm, input logic [7:0] ecount);
    @(negedge CLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== ecount) begin
      n_bad++;
      $display("FAIL %s_handshake: got rv=%b rdy=%b cnt=%h want 0 1 %h", nm, rsp_valid, req_ready, op_count, ecount);
    end
    $display("txn %s: data=%h cf=%b zf=%b op_count=%h", nm, rsp_data, rsp_cf, rsp_zf, op_count);
  endtask

  task automatic test_reset();
    CLR = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 8'h00; req_b = 8'h00; rsp_ready = 1'b1;
    #1 CLR = 1'b1;
    #1;
    n_cmp++;
    if (A !== 8'h00 || B !== 8'h00 || SU !== 1'b0 || FI !== 1'b0 || E0 !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_cf !== 1'b0 || rsp_zf !== 1'b0 ||
        op_count !== 8'h00 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_values: got A=%h B=%h SU=%b FI=%b E0=%b rv=%b d=%h cf=%b zf=%b cnt=%h rdy=%b want all zero, rdy=1",
               A, B, SU, FI, E0, rsp_valid, rsp_data, rsp_cf, rsp_zf, op_count, req_ready);
    end
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    $display("txn reset: released");
  endtask

  task automatic test_ops();
    issue(2'b00, 8'h05, 8'h03);
    run_to_resp("add", 1'b0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    check_done("add", 8'h01);
    issue(2'b01, 8'h10, 8'h10);
    run_to_resp("sub", 1'b0, 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    check_done("sub", 8'h02);
    issue(2'b00, 8'hFF, 8'h01);
    run_to_resp("add_ovf", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    check_done("add_ovf", 8'h03);
    issue(2'b10, 8'h03, 8'h05);
    run_to_resp("cmp", 1'b0, 8'h03, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_done("cmp", 8'h04);
    issue(2'b11, 8'h7F, 8'h33);
    run_to_resp("inc", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0);
    check_done("inc", 8'h05);
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    issue(2'b00, 8'h20, 8'h22);
    #1 begin req_a = 8'h99; req_b = 8'h01; end
    run_to_resp("bp_first", 1'b1, 8'h20, 8'h22, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h42 || req_ready !== 1'b0 || A !== 8'h20) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got rv=%b d=%h rdy=%b A=%h want 1 42 0 20", k, rsp_valid, rsp_data, req_ready, A);
      end
    end
    rsp_ready = 1'b1;
    check_done("bp_first", 8'h06);
    @(posedge CLK);
    run_to_resp("bp_second", 1'b0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 1'b0, 1'b0);
    check_done("bp_second", 8'h07);
  endtask

  task automatic test_clr_in_flag();
    issue(2'b01, 8'h44, 8'h11);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (FI !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_pre_flag: got FI=%b want 1", FI);
    end
    #2 CLR = 1'b1;
    #1;
    n_cmp++;
    if (FI !== 1'b0 || E0 !== 1'b0 || A !== 8'h00 || B !== 8'h00 || SU !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 8'h00 || op_count !== 8'h00) begin
      n_bad++;
      $display("FAIL clr_async: got FI=%b E0=%b A=%h B=%h SU=%b rv=%b d=%h cnt=%h want all zero",
               FI, E0, A, B, SU, rsp_valid, rsp_data, op_count);
    end
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_ready_after: got %b want 1", req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (rsp_valid !== 1'b0 || FI !== 1'b0) begin
        n_bad++;
        $display("FAIL clr_no_resp%0d: got rv=%b FI=%b want 0 0", k, rsp_valid, FI);
      end
    end
    $display("txn clr_in_flag: aborted, op_count=%h", op_count);
  endtask

  task automatic test_wrap();
    int accepts, last, cyc, overlap;
    logic saw_ff;
    accepts = 0; last = -1; cyc = 0; overlap = 0; saw_ff = 1'b0;
    req_op = 2'b00; req_a = 8'h01; req_b = 8'h01; rsp_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b1;
    while (accepts < 257 && cyc < 256 * (S + 4) + 100) begin
      if (FI && E0) overlap++;
      if (op_count == 8'hFF) saw_ff = 1'b1;
      if (req_ready) begin
        if (accepts == 1) begin
          n_cmp++;
          if (cyc - last != S + 4) begin
            n_bad++;
            $display("FAIL spacing: got %0d want %0d", cyc - last, S + 4);
          end
        end
        last = cyc;
        accepts++;
      end
      if (accepts < 257) begin
        @(negedge CLK);
        cyc++;
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (accepts != 257) begin
      n_bad++;
      $display("FAIL wrap_budget: got %0d accepts want 257", accepts);
    end
    n_cmp++;
    if (op_count !== 8'h00 || !saw_ff) begin
      n_bad++;
      $display("FAIL wrap_count: got cnt=%h saw_ff=%b want 00 1", op_count, saw_ff);
    end
    n_cmp++;
    if (overlap != 0) begin
      n_bad++;
      $display("FAIL wrap_overlap: got %0d want 0", overlap);
    end
    $display("txn wrap: 256 ops, op_count=%h", op_count);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_clr_in_flag();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 1: cycles operands are held on A/B before the flag strobe; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  sequencer can accept a request; high only in IDLE.
REQ-006 req_op  input  2  00 ADD, 01 SUB, 10 CMP (flags only), 11 INC (A+1).
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 A, B  output  8 each  operand registers driven to the ALU.
REQ-009 SU  output  1  ALU subtract select.
REQ-010 FI  output  1  ALU flag-register load strobe.
REQ-011 E0  output  1  ALU result output enable onto BUS.
REQ-012 BUS  input  8  ALU result; valid only while E0=1.
REQ-013 CF, ZF  input  1 each  ALU registered carry and zero flags.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts the result.
REQ-016 rsp_data  output  8  captured result.
REQ-017 rsp_cf, rsp_zf  output  1 each  captured flags.
REQ-018 op_count  output  8  completed-response counter.

Function
REQ-019 The FSM SHALL have states IDLE, SETTLE, FLAG, READ, RESP.
REQ-020 In IDLE, req_valid&&req_ready SHALL register A=req_a, SU=(op==SUB||op==CMP), B=(op==INC ? 8'h01 : req_b), store op, load settle counter with SETTLE_CYC-1, and enter SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter FLAG.
REQ-022 FLAG SHALL assert FI for exactly one cycle, then enter READ.
REQ-023 READ SHALL assert E0 for exactly one cycle for ADD/SUB/INC; for CMP, E0 SHALL remain 0.
REQ-024 At the end of READ, rsp_data SHALL capture BUS (8'h00 for CMP), rsp_cf/rsp_zf SHALL capture CF/ZF, and the FSM SHALL enter RESP.
REQ-025 RESP SHALL hold rsp_valid=1 with rsp_data/rsp_cf/rsp_zf stable until rsp_valid&&rsp_ready, then return to IDLE.
REQ-026 rsp_valid SHALL rise SETTLE_CYC+2 rising edges after the accept edge; minimum request-to-request spacing SHALL be SETTLE_CYC+4 cycles.
REQ-027 rsp_ready already high when rsp_valid rises SHALL complete the handshake in that same cycle.
REQ-028 FI and E0 SHALL never be high in the same cycle; both SHALL be low in IDLE, SETTLE and RESP.
REQ-029 A, B and SU SHALL remain constant from the accept edge until the next accept.
REQ-030 req_valid outside IDLE SHALL be ignored (req_ready=0); no request is queued.
REQ-031 op_count SHALL increment by 1 on each response handshake and wrap 8'hFF -> 8'h00.
REQ-032 Arithmetic belongs to the ALU; the sequencer SHALL NOT modify BUS, CF or ZF values.

Reset
REQ-033 CLR=1 SHALL immediately force state IDLE, A=B=8'h00, SU=FI=E0=0, rsp_valid=0, rsp_data=8'h00, rsp_cf=rsp_zf=0, op_count=8'h00, independent of CLK.
REQ-034 CLR asserted mid-operation (any state) SHALL abort the operation with no response; req_ready SHALL be 1 on the first cycle after CLR deasserts.

Verification
REQ-035 ADD a=0x05 b=0x03, rsp_ready=1, SETTLE_CYC=1 -> FI pulse 1 cycle, E0 pulse next cycle, rsp_valid 3 edges after accept, rsp_data=0x08, CF=0, ZF=0, op_count=1.
REQ-036 SUB a=0x10 b=0x10 -> SU=1, rsp_data=0x00, rsp_cf=1, rsp_zf=1; ADD a=0xFF b=0x01 -> rsp_data=0x00, rsp_cf=1, rsp_zf=1.
REQ-037 CMP a=0x03 b=0x05 -> E0 never asserted, rsp_data=0x00, rsp_cf=0, rsp_zf=0; INC a=0x7F -> B=0x01, rsp_data=0x80.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles with req_valid held high -> rsp_valid and rsp_data stable, req_ready=0, second request accepted only in IDLE after the handshake.
REQ-039 CLR pulse during FLAG -> FI drops asynchronously, all outputs at reset values, no rsp_valid, req_ready=1 next cycle; 256 completed ops -> op_count wraps to 0x00.
